// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB bus between two requesters.
// Round-robin grant in IDLE, APB SETUP/ACCESS sequencing, read data and
// error capture per requester, and an optional PREADY wait-state timeout.
module apb_master_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                pclk,
  input  logic                preset_n,
  input  logic                req0_valid,
  input  logic                req0_write,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_strb,
  output logic                req0_ack,
  output logic                req0_done,
  output logic [DATA_W-1:0]   req0_rdata,
  output logic                req0_slverr,
  output logic                req0_timeout,
  input  logic                req1_valid,
  input  logic                req1_write,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_strb,
  output logic                req1_ack,
  output logic                req1_done,
  output logic [DATA_W-1:0]   req1_rdata,
  output logic                req1_slverr,
  output logic                req1_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic                busy
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state;
  logic               owner;
  logic               last_grant;
  logic [CNT_W-1:0]   wait_cnt;

  logic               grant0;
  logic               grant1;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [DATA_W/8-1:0] sel_strb;
  logic               timeout_hit;
  logic               finish;
  logic               fin_slverr;
  logic               fin_timeout;
  logic [DATA_W-1:0]  fin_rdata;

  // Round-robin grant: a tie goes to the requester not served last.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && !grant0;
  end

  // Payload of the winning requester; strobes are zero for reads.
  always_comb begin
    sel_write = grant1 ? req1_write : req0_write;
    sel_addr  = grant1 ? req1_addr  : req0_addr;
    sel_wdata = grant1 ? req1_wdata : req0_wdata;
    sel_strb  = sel_write ? (grant1 ? req1_strb : req0_strb) : '0;
  end

  // Completion status: normal response wins over a coincident timeout.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_LIMIT);
    finish      = (state == ACCESS) && (pready || timeout_hit);
    fin_slverr  = pready ? pslverr : 1'b1;
    fin_timeout = !pready;
    fin_rdata   = (pready && !pwrite) ? prdata : '0;
  end

  assign req0_ack = preset_n && (state == IDLE) && grant0;
  assign req1_ack = preset_n && (state == IDLE) && grant1;
  assign busy     = (state != IDLE);

  // Transfer FSM with registered APB outputs and per-requester results.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      wait_cnt     <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      pstrb        <= '0;
      req0_done    <= 1'b0;
      req0_slverr  <= 1'b0;
      req0_timeout <= 1'b0;
      req0_rdata   <= '0;
      req1_done    <= 1'b0;
      req1_slverr  <= 1'b0;
      req1_timeout <= 1'b0;
      req1_rdata   <= '0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            state      <= SETUP;
            psel       <= 1'b1;
            owner      <= grant1;
            last_grant <= grant1;
            wait_cnt   <= '0;
            pwrite     <= sel_write;
            paddr      <= sel_addr;
            pwdata     <= sel_wdata;
            pstrb      <= sel_strb;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (finish) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            if (owner) begin
              req1_done    <= 1'b1;
              req1_slverr  <= fin_slverr;
              req1_timeout <= fin_timeout;
              req1_rdata   <= fin_rdata;
            end else begin
              req0_done    <= 1'b1;
              req0_slverr  <= fin_slverr;
              req0_timeout <= fin_timeout;
              req0_rdata   <= fin_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master controller that shares one APB bus (pclk/preset_n domain) between two independent requesters, e.g. a register-programming sequencer and a DMA-style engine feeding the UART APB slave. It arbitrates round-robin, runs the APB SETUP/ACCESS sequence, captures read data and error status, and enforces a PREADY timeout. The APB side connects directly to the bus monitored by the APB protocol checker.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width; strobe width is DATA_W/8
- TIMEOUT, 255, max ACCESS cycles with pready=0 before abort; 0 disables timeout
- pclk  in  1  APB clock, all logic rising-edge
- preset_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  (N=0,1) request pending; payload stable while valid and ack low
- reqN_write  in  1  1=write, 0=read
- reqN_addr  in  ADDR_W  transfer address
- reqN_wdata  in  DATA_W  write data
- reqN_strb  in  DATA_W/8  write strobes (driven to pstrb as 0 on reads)
- reqN_ack  out  1  combinational 1-cycle pulse: request accepted, payload captured
- reqN_done  out  1  registered 1-cycle pulse: transfer complete
- reqN_rdata  out  DATA_W  read data, valid with done; holds until next done of N
- reqN_slverr  out  1  error status, valid with done
- reqN_timeout  out  1  timeout flag, valid with done
- psel, penable, pwrite  out  1  APB controls
- paddr  out  ADDR_W; pwdata  out  DATA_W; pstrb  out  DATA_W/8
- prdata  in  DATA_W; pready  in  1; pslverr  in  1
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE -> SETUP -> ACCESS -> IDLE. Every transfer returns through IDLE (one idle cycle between transfers).
- IDLE: if any valid, grant one; ack of granted requester high same cycle; next edge: capture write/addr/wdata/strb (strb forced 0 for reads) into APB output regs, psel=1, state=SETUP, record owner.
- Arbitration (IDLE only): one valid -> grant it. Both valid -> grant the requester not granted last. last_grant resets to 1, so req0 wins the first tie.
- SETUP: psel=1, penable=0; next edge -> ACCESS, penable=1.
- ACCESS: wait counter increments each cycle pready=0.
  - pready=1: next edge psel=penable=0, state=IDLE, owner done=1, slverr=pslverr, timeout=0, rdata=prdata on read / 0 on write.
  - pready=0 and counter==TIMEOUT (TIMEOUT!=0): next edge psel=penable=0, IDLE, done=1, slverr=1, timeout=1, rdata=0.
- Non-owner outputs unchanged during a transfer. valid raised during a busy transfer waits for IDLE.
- paddr/pwrite/pwdata/pstrb hold their values after the transfer until the next capture.
- Counter width ceil(log2(TIMEOUT+1)), minimum 1; cleared on entry to SETUP.

## Timing
- Reset (async, immediate): state=IDLE, psel=penable=pwrite=0, paddr=pwdata=pstrb=0, all done/slverr/timeout=0, all rdata=0, last_grant=1, counter=0, busy=0. ack is 0 because state=IDLE with valid gated by reset.
- Reset mid-transfer: bus released immediately, transfer lost, no done pulse.
- Zero-wait transfer: valid+ack at cycle t; SETUP t+1; ACCESS t+2 (pready=1); done at t+3; next ack possible at t+3. Min 3 cycles/transfer.
- Each wait state adds one cycle; timeout abort: done at ACCESS-entry + TIMEOUT + 1.
- pready/pslverr/prdata sampled only in ACCESS; ignored otherwise.

## Test plan
- req0 write addr 0x0C data 0xA5 strb 0xF, pready=1 -> psel at t+1, penable t+2, paddr=0x0C pwdata=0xA5 pwrite=1, req0_done at t+3, slverr=0.
- req1 read addr 0x10, pready low 3 cycles then prdata=0x1234_5678 -> req1_done at t+6, rdata=0x12345678, penable held 4 cycles, paddr stable.
- Both valid continuously, 4 transfers -> grants req0, req1, req0, req1; acks alternate; one IDLE cycle between each.
- TIMEOUT=4, pready stuck 0 -> abort after 4 wait cycles, psel drops, req0_done with slverr=1 timeout=1 rdata=0; next request proceeds normally.
- pslverr=1 with pready on write -> slverr=1, timeout=0 for owner only.
- Assert preset_n low during ACCESS -> psel/penable low same cycle, no done; after release req0 wins tie first.
